// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and helpers for the bit-serial adder controller.
//               - sadd_state_t : controller state encoding (IDLE/RUN/DONE)
//               - cnt_width    : bit-counter width for a given operand width
//               - bit_inc      : increment built from XOR/AND, so the
//                                controller carries no adder of its own
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sadd_state_t;

    // Counter must hold 0..w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Ripple increment: bit i toggles when all lower bits are one.
    function automatic logic [31:0] bit_inc(input logic [31:0] v);
        logic [31:0] r;
        logic        c;
        r = '0;
        c = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[i] ^ c;
            c    = c & v[i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_fa.sv
`default_nettype none
// ============================================================================
// Module      : fullAdder
// Description : Single-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   cout      : carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. Sequences one fullAdder cell over
//               WIDTH cycles (LSB first) to compute a + b + cin.
// Ports       :
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request, sampled only while ready=1
//   a, b, cin         : operands, captured on the accepting edge
//   ready / busy      : state IDLE / state RUN
//   done              : one-cycle pulse, results valid
//   sum, cout, ovf    : registered results, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    sadd_state_t      r_state;
    sadd_state_t      w_state_nxt;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s_cell;
    logic             w_cout_cell;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt;

    fullAdder u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s_cell),
        .cout (w_cout_cell)
    );

    assign w_last    = (r_cnt == C_LAST);
    // New sum bit enters at the top; on the last step this is the full result.
    assign w_acc_nxt = {w_s_cell, r_acc};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_acc   <= w_acc_nxt[WIDTH-1:1];
                    r_carry <= w_cout_cell;
                    r_cnt   <= CW'(bit_inc(32'(r_cnt)));
                    if (w_last) begin
                        sum  <= w_acc_nxt;
                        cout <= w_cout_cell;
                        // On the MSB step the carry register is exactly the
                        // carry into the MSB, so no separate latch is needed.
                        ovf  <= r_carry ^ w_cout_cell;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode state only.
    assign ready = (r_state == IDLE);
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Scoreboard testbench for serial_add_ctrl, WIDTH=8 directed
//               cases and a WIDTH=4 exhaustive sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       ready8, busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    // WIDTH=4 instance
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       ready4, busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected {ovf, cout, sum}
    logic [9:0] q8[$];
    logic [5:0] q4[$];
    logic [9:0] m8_exp;
    logic [5:0] m4_exp;
    int         last_done4 = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: WIDTH=8
    always @(negedge clk) begin
        checks++;
        if (ready8 && busy8) begin
            errors++;
            $display("FAIL w8_ready_busy: got ready=1 busy=1, required not both");
        end
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected_done: got done with sum=%h, required no done", sum8);
            end else begin
                m8_exp = q8.pop_front();
                if ({ovf8, cout8, sum8} !== m8_exp) begin
                    errors++;
                    $display("FAIL w8_result: got ovf=%b cout=%b sum=%h, required ovf=%b cout=%b sum=%h",
                             ovf8, cout8, sum8, m8_exp[9], m8_exp[8], m8_exp[7:0]);
                end
            end
        end
    end

    // Monitor: WIDTH=4
    always @(negedge clk) begin
        checks++;
        if (ready4 && busy4) begin
            errors++;
            $display("FAIL w4_ready_busy: got ready=1 busy=1, required not both");
        end
        if (done4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL w4_unexpected_done: got done with sum=%h, required no done", sum4);
            end else begin
                m4_exp = q4.pop_front();
                if ({ovf4, cout4, sum4} !== m4_exp) begin
                    errors++;
                    $display("FAIL w4_result: got ovf=%b cout=%b sum=%h, required ovf=%b cout=%b sum=%h",
                             ovf4, cout4, sum4, m4_exp[5], m4_exp[4], m4_exp[3:0]);
                end
            end
            if (last_done4 >= 0) begin
                checks++;
                if (cyc - last_done4 != 6) begin
                    errors++;
                    $display("FAIL w4_done_spacing: got %0d cycles, required 6", cyc - last_done4);
                end
            end
            last_done4 = cyc;
        end
    end

    task automatic wait_ready8();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w8_wait_ready", {31'd0, ready8}, 32'd1);
    endtask

    // One WIDTH=8 operation with hand-computed result; checks latency,
    // busy length, result hold while running and ready return.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [7:0] es, input logic ec, input logic eo);
        logic [7:0] prev;
        int         k, nb;
        bit         seen;
        wait_ready8();
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        q8.push_back({eo, ec, es});
        prev = sum8;
        @(posedge clk);              // accepting edge
        #1 start8 = 1'b0;
        k = 0; nb = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (done8) seen = 1'b1;
            else begin
                if (busy8) nb++;
                chk("w8_sum_held", {24'd0, sum8}, {24'd0, prev});
            end
        end
        chk("w8_done_latency", k, 9);
        chk("w8_busy_cycles", nb, 8);
        @(negedge clk);
        chk("w8_ready_return", {31'd0, ready8}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, guard, s5, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready8}, 32'd1);
        chk("rst_busy",  {31'd0, busy8},  32'd0);
        chk("rst_done",  {31'd0, done8},  32'd0);
        chk("rst_sum",   {24'd0, sum8},   32'd0);
        chk("rst_cout",  {31'd0, cout8},  32'd0);
        chk("rst_ovf",   {31'd0, ovf8},   32'd0);
        chk("rst_ready4", {31'd0, ready4}, 32'd1);
        rst_n = 1'b1;

        // Directed WIDTH=8 cases
        op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

        // start held through RUN and DONE with different operands
        wait_ready8();
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back({1'b0, 1'b0, 8'h03});
        @(posedge clk);
        #1 a8 = 8'h11; b8 = 8'h22;
        repeat (9) @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        chk("w8_busy_test_ready", {31'd0, ready8}, 32'd1);
        chk("w8_busy_test_sum", {24'd0, sum8}, 32'h03);
        op8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN after 4 shifts
        wait_ready8();
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ready8}, 32'd1);
        chk("arst_busy",  {31'd0, busy8},  32'd0);
        chk("arst_done",  {31'd0, done8},  32'd0);
        chk("arst_sum",   {24'd0, sum8},   32'd0);
        chk("arst_cout",  {31'd0, cout8},  32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        // WIDTH=4 exhaustive, back-to-back
        idx = 0;
        guard = 0;
        while (idx < 512 && guard < 6000) begin
            @(negedge clk);
            guard++;
            if (ready4) begin
                {a4, b4, cin4} = 9'(idx);
                start4 = 1'b1;
                s5 = int'(a4) + int'(b4) + int'(cin4);
                q4.push_back({(a4[3] == b4[3]) && (s5[3] != a4[3]), s5[4], s5[3:0]});
                idx++;
            end else begin
                start4 = 1'b0;
            end
        end
        chk("w4_all_issued", idx, 512);
        @(negedge clk);
        start4 = 1'b0;

        // Drain
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q8", q8.size(), 0);
        chk("drain_q4", q4.size(), 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
